// File: rtl/dimm_cmd_tracker_if.sv
// rtl/dimm_cmd_tracker_if.sv - DDR4 command bus and tracker status bundle
interface dimm_cmd_tracker_if #(
  parameter int RANKS     = 2,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10
);
  localparam int NBT = RANKS * (2 ** (BGWIDTH + BAWIDTH));

  logic                 cke;
  logic [RANKS-1:0]     cs_n;
  logic                 act_n;
  logic [ADDRWIDTH-1:0] A;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;
  logic                 out_valid;
  logic [6:0]           out_cmd;
  logic                 out_ap;
  logic [RANKS-1:0]     out_rank;
  logic [BGWIDTH-1:0]   out_bg;
  logic [BAWIDTH-1:0]   out_ba;
  logic [ADDRWIDTH-1:0] out_row;
  logic [COLWIDTH-1:0]  out_col;
  logic                 err;
  logic [2:0]           err_code;
  logic [NBT-1:0]       bank_open;
  logic [RANKS-1:0]     sref;

  modport master (
    output cke, cs_n, act_n, A, bg, ba,
    input  out_valid, out_cmd, out_ap, out_rank, out_bg, out_ba, out_row, out_col,
           err, err_code, bank_open, sref
  );

  modport slave (
    input  cke, cs_n, act_n, A, bg, ba,
    output out_valid, out_cmd, out_ap, out_rank, out_bg, out_ba, out_row, out_col,
           err, err_code, bank_open, sref
  );
endinterface

// File: rtl/dimm_cmd_tracker.sv
// rtl/dimm_cmd_tracker.sv - multi-rank DDR4 command decoder with per-bank state, timing and self-refresh checks
module dimm_cmd_tracker #(
  parameter int RANKS     = 2,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int CNTWIDTH  = 4
) (
  input logic               clk,
  input logic               reset,
  dimm_cmd_tracker_if.slave bus
);
  localparam int NB  = 2 ** (BGWIDTH + BAWIDTH);
  localparam int NBT = RANKS * NB;
  localparam int IW  = $clog2(NBT);
  localparam int RW  = (RANKS > 1) ? $clog2(RANKS) : 1;
  localparam logic [CNTWIDTH-1:0] TRCD_LD = CNTWIDTH'(TRCD - 1);
  localparam logic [CNTWIDTH-1:0] TRP_LD  = CNTWIDTH'(TRP - 1);
  localparam int C_ACT = 6, C_PRE = 5, C_PREA = 4, C_RD = 3, C_WR = 2, C_REF = 1, C_SRE = 0;

  typedef enum logic [1:0] {IDLE, ACTIVATING, ACTIVE, PRECHARGING} bank_st_e;

  bank_st_e             st_q  [NBT];
  bank_st_e             st_d  [NBT];
  logic [CNTWIDTH-1:0]  tmr_q [NBT];
  logic [CNTWIDTH-1:0]  tmr_d [NBT];
  logic [ADDRWIDTH-1:0] row_q [NBT];
  logic [ADDRWIDTH-1:0] row_d [NBT];
  logic [RANKS-1:0]     sref_q, sref_d;

  logic                 valid_q, valid_d, ap_q, ap_d, err_q, err_d;
  logic [6:0]           cmd_q, cmd_d;
  logic [RANKS-1:0]     rank_q, rank_d;
  logic [BGWIDTH-1:0]   bg_q, bg_d;
  logic [BAWIDTH-1:0]   ba_q, ba_d;
  logic [ADDRWIDTH-1:0] orow_q, orow_d;
  logic [COLWIDTH-1:0]  col_q, col_d;
  logic [2:0]           code_q, code_d;

  logic [RANKS-1:0]     sel, rank_busy, rank_actv;
  logic [RW-1:0]        rank_idx;
  logic [IW-1:0]        idx;
  logic [6:0]           cmd;
  logic [2:0]           code;
  logic                 sref_exit, legal, rdwr;
  logic [NBT-1:0]       open_vec;

  always_comb begin
    sel      = ~bus.cs_n;
    rank_idx = '0;
    for (int r = RANKS - 1; r >= 0; r--) if (sel[r]) rank_idx = RW'(r);
    idx = IW'(int'(rank_idx) * NB) + IW'({bus.bg, bus.ba});

    cmd = '0;
    if (sel != '0) begin
      if (!bus.act_n) cmd[C_ACT] = 1'b1;
      else begin
        case (bus.A[16:14])
          3'b010:  if (bus.A[10]) cmd[C_PREA] = 1'b1; else cmd[C_PRE] = 1'b1;
          3'b101:  cmd[C_RD] = 1'b1;
          3'b100:  cmd[C_WR] = 1'b1;
          3'b001:  if (bus.cke) cmd[C_REF] = 1'b1; else cmd[C_SRE] = 1'b1;
          default: cmd = '0;
        endcase
      end
    end
    rdwr = cmd[C_RD] | cmd[C_WR];

    rank_busy = '0;
    rank_actv = '0;
    open_vec  = '0;
    for (int i = 0; i < NBT; i++) begin
      if (st_q[i] != IDLE)       rank_busy[i / NB] = 1'b1;
      if (st_q[i] == ACTIVATING) rank_actv[i / NB] = 1'b1;
      open_vec[i] = (st_q[i] == ACTIVE);
    end

    // Timers hold remaining cycles minus one, so a bank is usable exactly TRCD/TRP cycles after its command.
    for (int i = 0; i < NBT; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      row_d[i] = row_q[i];
      if (st_q[i] == ACTIVATING || st_q[i] == PRECHARGING) begin
        if (tmr_q[i] <= CNTWIDTH'(1)) begin
          tmr_d[i] = '0;
          st_d[i]  = (st_q[i] == ACTIVATING) ? ACTIVE : IDLE;
        end else begin
          tmr_d[i] = tmr_q[i] - CNTWIDTH'(1);
        end
      end
    end

    // A cke=1 cycle while any rank is in self-refresh only performs the exit.
    sref_exit = (|sref_q) && bus.cke;
    sref_d    = sref_exit ? '0 : sref_q;

    code = '0;
    if (cmd != '0 && !sref_exit) begin
      if (|(sel & sref_q))                                       code = 3'd6;
      else if ($countones(sel) > 1 && !(cmd[C_REF] || cmd[C_PREA])) code = 3'd5;
      else if (cmd[C_ACT] && st_q[idx] != IDLE)                  code = 3'd1;
      else if (rdwr && st_q[idx] == ACTIVATING)                  code = 3'd2;
      else if (rdwr && st_q[idx] != ACTIVE)                      code = 3'd3;
      else if ((cmd[C_REF] || cmd[C_SRE]) && |(sel & rank_busy)) code = 3'd4;
      else if (cmd[C_PRE] && st_q[idx] == ACTIVATING)            code = 3'd7;
      else if (cmd[C_PREA] && |(sel & rank_actv))                code = 3'd7;
    end
    legal = (cmd != '0) && !sref_exit && (code == 3'd0);

    valid_d = legal;
    err_d   = (code != 3'd0);
    code_d  = code;
    cmd_d   = '0;
    ap_d    = 1'b0;
    rank_d  = '0;
    bg_d    = '0;
    ba_d    = '0;
    orow_d  = '0;
    col_d   = '0;
    if (legal) begin
      cmd_d  = cmd;
      rank_d = sel;
      bg_d   = bus.bg;
      ba_d   = bus.ba;
      if (cmd[C_ACT]) begin
        st_d[idx]  = (TRCD == 1) ? ACTIVE : ACTIVATING;
        tmr_d[idx] = TRCD_LD;
        row_d[idx] = bus.A;
        orow_d     = bus.A;
      end
      if (rdwr) begin
        ap_d   = bus.A[10];
        col_d  = bus.A[COLWIDTH-1:0];
        orow_d = row_q[idx];
      end
      if ((rdwr && bus.A[10]) || (cmd[C_PRE] && st_q[idx] == ACTIVE)) begin
        st_d[idx]  = (TRP == 1) ? IDLE : PRECHARGING;
        tmr_d[idx] = TRP_LD;
      end
      if (cmd[C_PREA]) begin
        for (int i = 0; i < NBT; i++) begin
          if (sel[i / NB] && st_q[i] == ACTIVE) begin
            st_d[i]  = (TRP == 1) ? IDLE : PRECHARGING;
            tmr_d[i] = TRP_LD;
          end
        end
      end
      if (cmd[C_SRE]) sref_d[rank_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBT; i++) begin
        st_q[i]  <= IDLE;
        tmr_q[i] <= '0;
        row_q[i] <= '0;
      end
      sref_q  <= '0;
      valid_q <= 1'b0;
      cmd_q   <= '0;
      ap_q    <= 1'b0;
      rank_q  <= '0;
      bg_q    <= '0;
      ba_q    <= '0;
      orow_q  <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      st_q    <= st_d;
      tmr_q   <= tmr_d;
      row_q   <= row_d;
      sref_q  <= sref_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      ap_q    <= ap_d;
      rank_q  <= rank_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      orow_q  <= orow_d;
      col_q   <= col_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_cmd   = cmd_q;
  assign bus.out_ap    = ap_q;
  assign bus.out_rank  = rank_q;
  assign bus.out_bg    = bg_q;
  assign bus.out_ba    = ba_q;
  assign bus.out_row   = orow_q;
  assign bus.out_col   = col_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  assign bus.bank_open = open_vec;
  assign bus.sref      = sref_q;
endmodule

// File: tb/tb_dimm_cmd_tracker.sv
// tb/tb_dimm_cmd_tracker.sv - directed and randomized check of dimm_cmd_tracker against a timestamp model
module tb_dimm_cmd_tracker;
  localparam int RANKS = 2, BGW = 2, BAW = 2, AW = 17, CW = 10, TRCD = 4, TRP = 4;
  localparam int NB = 16, NBT = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dimm_cmd_tracker_if #(.RANKS(RANKS), .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW)) bus ();

  dimm_cmd_tracker #(
    .RANKS(RANKS), .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW),
    .TRCD(TRCD), .TRP(TRP), .CNTWIDTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;

  bit              opened [NBT];
  logic [AW-1:0]   row_m  [NBT];
  longint          t_act  [NBT];
  longint          t_pre  [NBT];
  bit [RANKS-1:0]  sref_m;

  logic            e_valid, e_ap, e_err;
  logic [6:0]      e_cmd;
  logic [1:0]      e_rank, e_bg, e_ba;
  logic [AW-1:0]   e_row;
  logic [CW-1:0]   e_col;
  logic [2:0]      e_code;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // 0 idle, 1 activating, 2 active, 3 precharging -- derived from command timestamps
  function automatic int phase(input int i);
    if (opened[i]) return (cyc >= t_act[i] + TRCD) ? 2 : 1;
    return (cyc >= t_pre[i] + TRP) ? 0 : 3;
  endfunction

  function automatic int count_phase(input logic [RANKS-1:0] s, input int ph);
    int n = 0;
    for (int i = 0; i < NBT; i++) if (s[i / NB] && phase(i) == ph) n++;
    return n;
  endfunction

  function automatic logic [AW-1:0] fa(input logic [2:0] c, input logic a10, input logic [CW-1:0] col);
    return {c, 3'b000, a10, col};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NBT; i++) begin
      opened[i] = 0;
      row_m[i]  = '0;
      t_act[i]  = 0;
      t_pre[i]  = -1000;
    end
    sref_m = '0;
  endtask

  task automatic close_bank(input int i);
    opened[i] = 0;
    t_pre[i]  = cyc;
  endtask

  task automatic model_step(input logic [1:0] cs, input logic an, input logic [AW-1:0] a,
                            input logic [1:0] g, input logic [1:0] b, input logic ck, input logic rst);
    logic [RANKS-1:0] s;
    int kind, rk, bi, code, nsel;
    {e_valid, e_ap, e_err, e_cmd, e_rank, e_bg, e_ba, e_row, e_col, e_code} = '0;
    if (rst) begin
      model_reset();
      return;
    end
    s    = ~cs;
    nsel = $countones(s);
    kind = -1;
    if (s != '0) begin
      if (!an) kind = 0;
      else begin
        case (a[16:14])
          3'b010:  kind = a[10] ? 2 : 1;
          3'b101:  kind = 3;
          3'b100:  kind = 4;
          3'b001:  kind = ck ? 5 : 6;
          default: kind = -1;
        endcase
      end
    end
    if (sref_m != '0 && ck) begin
      sref_m = '0;
      return;
    end
    if (kind < 0) return;
    rk = 0;
    for (int r = RANKS - 1; r >= 0; r--) if (s[r]) rk = r;
    bi = rk * NB + int'(g) * 4 + int'(b);
    code = 0;
    if ((s & sref_m) != '0)                                         code = 6;
    else if (nsel > 1 && kind != 5 && kind != 2)                    code = 5;
    else if (kind == 0 && phase(bi) != 0)                           code = 1;
    else if ((kind == 3 || kind == 4) && phase(bi) == 1)            code = 2;
    else if ((kind == 3 || kind == 4) && phase(bi) != 2)            code = 3;
    else if ((kind == 5 || kind == 6) && count_phase(s, 0) != nsel * NB) code = 4;
    else if (kind == 1 && phase(bi) == 1)                           code = 7;
    else if (kind == 2 && count_phase(s, 1) != 0)                   code = 7;
    if (code != 0) begin
      e_err  = 1'b1;
      e_code = 3'(code);
      return;
    end
    e_valid = 1'b1;
    e_cmd   = 7'(7'b1000000 >> kind);
    e_rank  = s;
    e_bg    = g;
    e_ba    = b;
    case (kind)
      0: begin
        opened[bi] = 1;
        t_act[bi]  = cyc;
        row_m[bi]  = a;
        e_row      = a;
      end
      1: if (phase(bi) == 2) close_bank(bi);
      2: for (int i = 0; i < NBT; i++) if (s[i / NB] && phase(i) == 2) close_bank(i);
      3, 4: begin
        e_row = row_m[bi];
        e_ap  = a[10];
        e_col = a[CW-1:0];
        if (a[10]) close_bank(bi);
      end
      6: sref_m[rk] = 1'b1;
      default: ;
    endcase
  endtask

  task automatic tick(input logic [1:0] cs, input logic an, input logic [AW-1:0] a,
                      input logic [1:0] g, input logic [1:0] b, input logic ck, input logic rst);
    logic [NBT-1:0] e_open;
    @(negedge clk);
    bus.cs_n  = cs;
    bus.act_n = an;
    bus.A     = a;
    bus.bg    = g;
    bus.ba    = b;
    bus.cke   = ck;
    reset     = rst;
    model_step(cs, an, a, g, b, ck, rst);
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NBT; i++) e_open[i] = (phase(i) == 2);
    check_eq("out_valid", 64'(bus.out_valid), 64'(e_valid));
    check_eq("out_cmd",   64'(bus.out_cmd),   64'(e_cmd));
    check_eq("out_ap",    64'(bus.out_ap),    64'(e_ap));
    check_eq("out_rank",  64'(bus.out_rank),  64'(e_rank));
    check_eq("out_bg",    64'(bus.out_bg),    64'(e_bg));
    check_eq("out_ba",    64'(bus.out_ba),    64'(e_ba));
    check_eq("out_row",   64'(bus.out_row),   64'(e_row));
    check_eq("out_col",   64'(bus.out_col),   64'(e_col));
    check_eq("err",       64'(bus.err),       64'(e_err));
    check_eq("err_code",  64'(bus.err_code),  64'(e_code));
    check_eq("bank_open", 64'(bus.bank_open), 64'(e_open));
    check_eq("sref",      64'(bus.sref),      64'(sref_m));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(2'b11, 1'b1, '0, 2'd0, 2'd0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [1:0]    cs, g, b;
    logic [AW-1:0] a;
    logic          an, ck, rst;
    int            r, kind;

    model_reset();
    tick(2'b11, 1'b1, '0, 2'd0, 2'd0, 1'b1, 1'b1);
    tick(2'b11, 1'b1, '0, 2'd0, 2'd0, 1'b1, 1'b1);

    tick(2'b10, 1'b0, 17'h1ABCD, 2'd1, 2'd2, 1'b1, 1'b0);
    idle(3);
    check_eq("tp_open_at_trcd", 64'(bus.bank_open[6]), 64'd1);
    tick(2'b10, 1'b1, fa(3'b101, 1'b0, 10'h155), 2'd1, 2'd2, 1'b1, 1'b0);
    check_eq("tp_rd_row", 64'(bus.out_row), 64'h1ABCD);
    check_eq("tp_rd_col", 64'(bus.out_col), 64'h155);
    check_eq("tp_rd_cmd", 64'(bus.out_cmd), 64'b0001000);
    tick(2'b10, 1'b1, fa(3'b010, 1'b0, '0), 2'd1, 2'd2, 1'b1, 1'b0);
    idle(3);

    tick(2'b10, 1'b0, 17'h00123, 2'd0, 2'd1, 1'b1, 1'b0);
    idle(2);
    tick(2'b10, 1'b1, fa(3'b101, 1'b0, 10'h001), 2'd0, 2'd1, 1'b1, 1'b0);
    check_eq("tp_trcd_code", 64'(bus.err_code), 64'd2);
    check_eq("tp_trcd_valid", 64'(bus.out_valid), 64'd0);
    tick(2'b10, 1'b1, fa(3'b101, 1'b1, 10'h002), 2'd0, 2'd1, 1'b1, 1'b0);
    check_eq("tp_rda_ap", 64'(bus.out_ap), 64'd1);
    idle(2);
    tick(2'b10, 1'b0, 17'h0ABCD, 2'd0, 2'd1, 1'b1, 1'b0);
    check_eq("tp_trp_code", 64'(bus.err_code), 64'd1);
    tick(2'b10, 1'b0, 17'h0ABCD, 2'd0, 2'd1, 1'b1, 1'b0);
    check_eq("tp_act_after_trp", 64'(bus.out_valid), 64'd1);
    idle(3);
    tick(2'b10, 1'b1, fa(3'b100, 1'b0, 10'h3FF), 2'd0, 2'd1, 1'b1, 1'b0);
    check_eq("tp_new_row", 64'(bus.out_row), 64'h0ABCD);
    tick(2'b10, 1'b1, fa(3'b010, 1'b0, '0), 2'd0, 2'd1, 1'b1, 1'b0);
    idle(3);

    tick(2'b10, 1'b0, 17'h11111, 2'd0, 2'd0, 1'b1, 1'b0);
    tick(2'b01, 1'b0, 17'h22222, 2'd0, 2'd0, 1'b1, 1'b0);
    idle(3);
    tick(2'b00, 1'b1, fa(3'b001, 1'b0, '0), 2'd0, 2'd0, 1'b1, 1'b0);
    check_eq("tp_ref_busy", 64'(bus.err_code), 64'd4);
    tick(2'b00, 1'b1, fa(3'b010, 1'b1, '0), 2'd0, 2'd0, 1'b1, 1'b0);
    idle(3);
    tick(2'b00, 1'b1, fa(3'b001, 1'b0, '0), 2'd0, 2'd0, 1'b1, 1'b0);
    check_eq("tp_ref_valid", 64'(bus.out_valid), 64'd1);
    check_eq("tp_ref_rank", 64'(bus.out_rank), 64'b11);

    tick(2'b01, 1'b1, fa(3'b001, 1'b0, '0), 2'd0, 2'd0, 1'b0, 1'b0);
    check_eq("tp_sre", 64'(bus.sref), 64'b10);
    tick(2'b01, 1'b0, 17'h00042, 2'd0, 2'd0, 1'b0, 1'b0);
    check_eq("tp_sref_code", 64'(bus.err_code), 64'd6);
    tick(2'b01, 1'b0, 17'h00042, 2'd0, 2'd0, 1'b1, 1'b0);
    check_eq("tp_srx_ignored", 64'({bus.out_valid, bus.err, bus.sref}), 64'd0);

    tick(2'b10, 1'b0, 17'h00777, 2'd1, 2'd1, 1'b1, 1'b0);
    idle(1);
    tick(2'b10, 1'b1, fa(3'b101, 1'b0, '0), 2'd1, 2'd1, 1'b1, 1'b1);
    check_eq("tp_rst_open", 64'(bus.bank_open), 64'd0);
    tick(2'b10, 1'b1, fa(3'b101, 1'b0, '0), 2'd1, 2'd1, 1'b1, 1'b0);
    check_eq("tp_rst_rd", 64'(bus.err_code), 64'd3);

    for (int k = 0; k < 3000; k++) begin
      r    = $urandom_range(0, 99);
      cs   = (r < 30) ? 2'b11 : (r < 40) ? 2'b00 : ($urandom_range(0, 1) != 0 ? 2'b10 : 2'b01);
      kind = $urandom_range(0, 9);
      a    = AW'($urandom);
      an   = 1'b1;
      case (kind)
        0, 1:    an = 1'b0;
        2, 3:    a[16:14] = 3'b010;
        4, 5:    a[16:14] = 3'b101;
        6:       a[16:14] = 3'b100;
        7:       a[16:14] = 3'b001;
        default: ;
      endcase
      g   = 2'($urandom_range(0, 1));
      b   = 2'($urandom_range(0, 1));
      ck  = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick(cs, an, a, g, b, ck, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dimm_cmd_tracker.md
Name: dimm_cmd_tracker

Overview:
- Multi-rank DDR4 command front-end for the DRAM emulation path.
- Decodes cs_n/act_n/A16..A14/A10/cke into one-hot commands and keeps a per-rank, per-bank state machine with open-row storage and tRCD/tRP countdowns.
- Emits one registered, validated command per cycle toward the chip models and flags protocol violations.
- Replaces the single shared open-row register with per-bank tracking across RANKS ranks, and adds timing checks and self-refresh tracking.

Parameters:
RANKS, 2, number of ranks; cs_n width
BGWIDTH, 2, bank-group address bits; 2**BGWIDTH groups
BAWIDTH, 2, bank address bits; 2**BAWIDTH banks per group
ADDRWIDTH, 17, address bus width; A[16:14] are RAS_n/CAS_n/WE_n; must be >= 17
COLWIDTH, 10, column bits taken from A[COLWIDTH-1:0]
TRCD, 4, cycles from ACT until RD/WR is legal; must be >= 1
TRP, 4, cycles from PRE/PREA/RDA/WRA until ACT is legal; must be >= 1
CNTWIDTH, 4, timer width; must hold max(TRCD,TRP)

Ports:
clk  in  1  command clock; all state changes on posedge
reset  in  1  synchronous, active-high reset
cke  in  1  clock enable; selects REF vs SRE, exits self-refresh
cs_n  in  RANKS  per-rank chip select, active low
act_n  in  1  activate command input, active low
A  in  ADDRWIDTH  row address / command / column bus
bg  in  BGWIDTH  bank group
ba  in  BAWIDTH  bank
out_valid  out  1  legal command presented this cycle
out_cmd  out  7  one-hot {ACT,PRE,PREA,RD,WR,REF,SRE}
out_ap  out  1  auto-precharge, for RD/WR
out_rank  out  RANKS  one-hot target rank(s)
out_bg  out  BGWIDTH  registered bg
out_ba  out  BAWIDTH  registered ba
out_row  out  ADDRWIDTH  for ACT: new row; for RD/WR: open row of the target bank
out_col  out  COLWIDTH  registered column
err  out  1  violation pulse
err_code  out  3  violation cause; 0 when err=0
bank_open  out  RANKS*2**(BGWIDTH+BAWIDTH)  1 = bank ACTIVE; index {rank,bg,ba}
sref  out  RANKS  rank is in self-refresh

Behaviour:
- Reset state: all outputs 0, all banks IDLE, timers 0, rows 0, sref 0. Reset has priority over any command sampled in the same cycle and aborts all countdowns.
- A command is sampled when at least one cs_n bit is low. All cs_n high is a deselect: no outputs, but timers still count.
- Decode:
  - act_n=0: ACT.
  - act_n=1, {A16,A15,A14}=010: PRE (A10=0) or PREA (A10=1).
  - 101: RD; 100: WR; A10 drives out_ap.
  - 001: REF if cke=1, SRE if cke=0.
  - Any other code is NOP: no output, no error.
- Latency: outputs are registered one cycle after sampling. out_valid and err are one-cycle pulses and never both 1. An illegal command causes no state change.
- Bank FSM (per rank, per bank):
  - IDLE --ACT--> ACTIVATING: row stored, timer loaded with TRCD.
  - ACTIVATING: timer decrements each cycle; becomes ACTIVE when the timer reaches 0. With ACT sampled at cycle n, RD/WR is legal from n+TRCD.
  - ACTIVE --PRE, or PREA, or RD/WR with A10=1--> PRECHARGING: timer loaded with TRP. ACT is legal from m+TRP, where m is the sampling cycle.
  - PRECHARGING --timer reaches 0--> IDLE.
  - PRE to an IDLE or PRECHARGING bank is legal with no state change. PREA applies the same rule to every bank of the rank.
- Error codes (first match wins):
  - 6: any command to a rank with sref=1.
  - 5: more than one cs_n low for a command other than REF/PREA. Multi-rank REF/PREA is legal and applies to every selected rank.
  - 1: ACT to a bank not IDLE.
  - 2: RD/WR to an ACTIVATING bank (tRCD violation).
  - 3: RD/WR to an IDLE or PRECHARGING bank.
  - 4: REF/SRE when any bank of the target rank is not IDLE.
  - 7: PRE/PREA to an ACTIVATING bank.
- Self-refresh: a legal SRE sets sref[r]. sref[r] clears on the first cycle with cke=1, and any command sampled in that cycle is ignored with no error.
- out_row for RD/WR is the stored row of the addressed bank, read before any auto-precharge update.

Test Plan:
- ACT rank0 bg1 ba2 row 0x1ABCD, then RD col 0x155 at n+4 -> out_cmd=ACT then RD, out_row=0x1ABCD, out_col=0x155, bank_open bit set at n+4, err=0.
- ACT then RD at n+3 (TRCD=4) -> err=1, err_code=2, no out_valid; a retried RD at n+4 is legal.
- RDA at m, ACT to the same bank at m+3 -> err_code=1; ACT at m+4 -> legal, new row stored.
- Open banks in rank0 and rank1; REF with cs_n=2'b00 -> err_code=4. PREA with both cs_n low, wait TRP, REF -> out_valid=1, out_rank=2'b11.
- SRE with cke=0 on an idle rank1 -> sref=2'b10. ACT to rank1 -> err_code=6. cke=1 -> sref clears, command in that cycle ignored.
- ACT at cycle n, reset asserted at n+2 -> next cycle all outputs 0 and bank_open=0. RD after reset -> err_code=3.
